// File: rtl/pwm_tone_arbiter.sv
// Round-robin arbiter that lends the audio PWM duty reference to one of two
// tone requesters and plays the granted tone as a square wave, then a silent gap.
module pwm_tone_arbiter #(
  parameter int unsigned REF_W     = 5,
  parameter int unsigned HALF_W    = 16,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned DUTY_HI   = 16,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              req0,
  input  logic              req1,
  input  logic [HALF_W-1:0] half0,
  input  logic [HALF_W-1:0] half1,
  input  logic [DUR_W-1:0]  dur0,
  input  logic [DUR_W-1:0]  dur1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic              owner,
  output logic [REF_W-1:0]  pwm_ref
);

  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS == 0) ? '0 : GAP_W'(GAP_TICKS - 1);
  localparam logic [REF_W-1:0] DUTY     = REF_W'(DUTY_HI);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   half_q, half_d, half_cnt_q, half_cnt_d, half_last;
  logic [DUR_W-1:0]    dur_q, dur_d, dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                phase_q, phase_d;
  logic                pref_q, pref_d;
  logic                owner_q, owner_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                busy_q, busy_d;
  logic [REF_W-1:0]    pwm_ref_q, pwm_ref_d;
  logic                grant_ch;
  logic [DUR_W-1:0]    grant_dur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      half_q     <= '0;
      dur_q      <= '0;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      phase_q    <= 1'b0;
      pref_q     <= 1'b0;
      owner_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      pwm_ref_q  <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      dur_q      <= dur_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      phase_q    <= phase_d;
      pref_q     <= pref_d;
      owner_q    <= owner_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      pwm_ref_q  <= pwm_ref_d;
    end
  end

  // pref_q names the channel that wins a tie; it always points away from the last grant
  assign grant_ch  = (req0 && req1) ? pref_q : req1;
  assign grant_dur = grant_ch ? dur1 : dur0;
  assign half_last = (half_q == '0) ? '0 : half_q - HALF_W'(1);

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    dur_d      = dur_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    phase_d    = phase_q;
    pref_d     = pref_q;
    owner_d    = owner_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = busy_q;
    pwm_ref_d  = pwm_ref_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d    = grant_ch;
          pref_d     = ~grant_ch;
          ack0_d     = ~grant_ch;
          ack1_d     = grant_ch;
          half_d     = grant_ch ? half1 : half0;
          dur_d      = grant_dur;
          half_cnt_d = '0;
          dur_cnt_d  = '0;
          gap_cnt_d  = '0;
          phase_d    = 1'b1;
          busy_d     = 1'b1;
          if (grant_dur == '0) begin
            state_d   = S_GAP;
            pwm_ref_d = '0;
          end else begin
            state_d   = S_PLAY;
            pwm_ref_d = DUTY;
          end
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (dur_cnt_q == dur_q - DUR_W'(1)) begin
            state_d   = S_GAP;
            phase_d   = 1'b0;
            pwm_ref_d = '0;
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
            if (half_cnt_q == half_last) begin
              phase_d    = ~phase_q;
              half_cnt_d = '0;
            end else begin
              half_cnt_d = half_cnt_q + HALF_W'(1);
            end
            pwm_ref_d = phase_d ? DUTY : '0;
          end
        end
      end
      S_GAP: begin
        pwm_ref_d = '0;
        if ((GAP_TICKS == 0) || (frame_tick && (gap_cnt_q == GAP_LAST))) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else if (frame_tick) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        pwm_ref_d = '0;
      end
    endcase
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign pwm_ref = pwm_ref_q;

endmodule

// File: tb/tb_pwm_tone_arbiter.sv
// Directed bench for pwm_tone_arbiter: square-wave sequencing, round-robin
// arbitration, zero duration/half-period, mid-tone reset and a GAP_TICKS=0 build.
module tb_pwm_tone_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, g_req0 = 1'b0;
  logic [15:0] half0 = '0, half1 = '0, dur0 = '0, dur1 = '0;
  logic        ack0, ack1, done0, done1, busy, owner;
  logic [4:0]  pwm_ref;
  logic        g_ack0, g_ack1, g_done0, g_done1, g_busy, g_owner;
  logic [4:0]  g_pwm_ref;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pwm_tone_arbiter dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .req0(req0), .req1(req1), .half0(half0), .half1(half1), .dur0(dur0), .dur1(dur1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .busy(busy), .owner(owner), .pwm_ref(pwm_ref)
  );

  pwm_tone_arbiter #(.GAP_TICKS(0)) dut_g0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .req0(g_req0), .req1(1'b0), .half0(half0), .half1(half1), .dur0(dur0), .dur1(dur1),
    .ack0(g_ack0), .ack1(g_ack1), .done0(g_done0), .done1(g_done1),
    .busy(g_busy), .owner(g_owner), .pwm_ref(g_pwm_ref)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise frame_tick for exactly one sampling edge; returns where its effect is visible
  task automatic tick1();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) idle(1);
      tick1();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++; if ({ack0, ack1, done0, done1, busy, owner} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {ack0, ack1, done0, done1, busy, owner}); end
    checks++; if (pwm_ref !== 5'd0) begin errors++; $display("FAIL reset_pwm: got %0d want 0", pwm_ref); end
    checks++; if ({g_busy, g_pwm_ref} !== 6'b0) begin errors++; $display("FAIL reset_g0: got %b want 000000", {g_busy, g_pwm_ref}); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_square_wave();
    int exp_pwm [8] = '{16, 16, 0, 0, 16, 16, 0, 0};
    half0 = 16'd2; dur0 = 16'd8; req0 = 1'b1;
    idle(1);
    checks++; if ({ack0, ack1, busy, owner} !== 4'b1010) begin errors++; $display("FAIL sq_grant: got %b want 1010", {ack0, ack1, busy, owner}); end
    req0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (pwm_ref !== 5'(exp_pwm[i])) begin errors++; $display("FAIL sq_pwm_frame%0d: got %0d want %0d", i, pwm_ref, exp_pwm[i]); end
      tick1();
      if (i == 0) begin
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL sq_ack_pulse: got %0b want 0", ack0); end
      end
      idle(3);
    end
    checks++; if ({busy, pwm_ref} !== 6'b100000) begin errors++; $display("FAIL sq_gap_entry: got busy=%0b pwm=%0d want busy=1 pwm=0", busy, pwm_ref); end
    for (int g = 0; g < 4; g++) begin
      tick1();
      checks++; if (done0 !== (g == 3)) begin errors++; $display("FAIL sq_done_gap%0d: got %0b want %0b", g, done0, (g == 3)); end
      if (g < 3) idle(3);
    end
    checks++; if ({busy, owner, pwm_ref, done1} !== 8'b0) begin errors++; $display("FAIL sq_after_done: got %b want 00000000", {busy, owner, pwm_ref, done1}); end
    idle(1);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL sq_done_pulse: got %0b want 0", done0); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; idle(2); reset = 1'b0;
    half0 = 16'd1; dur0 = 16'd1; half1 = 16'd1; dur1 = 16'd1;
    req0 = 1'b1; req1 = 1'b1;
    idle(1);
    checks++; if ({ack0, ack1, owner} !== 3'b100) begin errors++; $display("FAIL rr_first: got %b want 100", {ack0, ack1, owner}); end
    ticks(1); idle(1); ticks(4);
    checks++; if ({done0, ack1} !== 2'b10) begin errors++; $display("FAIL rr_done0: got %b want 10", {done0, ack1}); end
    idle(1);
    checks++; if ({ack0, ack1, owner} !== 3'b011) begin errors++; $display("FAIL rr_second: got %b want 011", {ack0, ack1, owner}); end
    ticks(1); idle(1); ticks(4);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL rr_done1: got %0b want 1", done1); end
    idle(1);
    checks++; if ({ack0, ack1, owner} !== 3'b100) begin errors++; $display("FAIL rr_third: got %b want 100", {ack0, ack1, owner}); end
    req0 = 1'b0; req1 = 1'b0;
    ticks(1); idle(1); ticks(4);
    checks++; if ({done0, busy} !== 2'b10) begin errors++; $display("FAIL rr_final_done: got %b want 10", {done0, busy}); end
    idle(1);
  endtask

  task automatic test_zero_fields();
    half1 = 16'd5; dur1 = 16'd0; req1 = 1'b1;
    idle(1);
    checks++; if ({ack1, busy, pwm_ref} !== 7'b1100000) begin errors++; $display("FAIL z_dur0_grant: got ack1=%0b busy=%0b pwm=%0d want 1 1 0", ack1, busy, pwm_ref); end
    req1 = 1'b0;
    ticks(3);
    checks++; if ({done1, pwm_ref} !== 6'b0) begin errors++; $display("FAIL z_dur0_early: got done1=%0b pwm=%0d want 0 0", done1, pwm_ref); end
    idle(1); ticks(1);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL z_dur0_done: got %0b want 1", done1); end
    half1 = 16'd0; dur1 = 16'd3; req1 = 1'b1;
    idle(1);
    checks++; if ({ack1, pwm_ref} !== 6'b110000) begin errors++; $display("FAIL z_half0_f0: got ack1=%0b pwm=%0d want 1 16", ack1, pwm_ref); end
    req1 = 1'b0;
    ticks(1);
    checks++; if (pwm_ref !== 5'd0) begin errors++; $display("FAIL z_half0_f1: got %0d want 0", pwm_ref); end
    idle(1); ticks(1);
    checks++; if (pwm_ref !== 5'd16) begin errors++; $display("FAIL z_half0_f2: got %0d want 16", pwm_ref); end
    idle(1); ticks(1);
    checks++; if ({busy, pwm_ref} !== 6'b100000) begin errors++; $display("FAIL z_half0_gap: got busy=%0b pwm=%0d want 1 0", busy, pwm_ref); end
    idle(1); ticks(4);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL z_half0_done: got %0b want 1", done1); end
    idle(1);
  endtask

  task automatic test_nonpreempt();
    half0 = 16'd1; dur0 = 16'd2; req0 = 1'b1;
    idle(1);
    checks++; if ({ack0, owner} !== 2'b10) begin errors++; $display("FAIL np_ack0: got %b want 10", {ack0, owner}); end
    req0 = 1'b0;
    ticks(1);
    checks++; if (pwm_ref !== 5'd0) begin errors++; $display("FAIL np_toggle: got %0d want 0", pwm_ref); end
    half1 = 16'd1; dur1 = 16'd1; req1 = 1'b1;
    idle(2);
    ticks(1);
    idle(1); ticks(3);
    checks++; if ({ack1, busy, owner} !== 3'b010) begin errors++; $display("FAIL np_wait: got %b want 010", {ack1, busy, owner}); end
    idle(1); ticks(1);
    checks++; if ({done0, ack1} !== 2'b10) begin errors++; $display("FAIL np_done0: got %b want 10", {done0, ack1}); end
    idle(1);
    checks++; if ({ack1, owner} !== 2'b11) begin errors++; $display("FAIL np_ack1: got %b want 11", {ack1, owner}); end
    req1 = 1'b0;
    ticks(1); idle(1); ticks(4);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL np_done1: got %0b want 1", done1); end
    idle(1);
  endtask

  task automatic test_reset_mid_tone();
    int seen_done;
    half0 = 16'd2; dur0 = 16'd8; req0 = 1'b1;
    idle(1); req0 = 1'b0;
    ticks(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++; if ({busy, pwm_ref, done0, ack0} !== 8'b0) begin errors++; $display("FAIL rst_mid: got busy=%0b pwm=%0d done0=%0b ack0=%0b want all 0", busy, pwm_ref, done0, ack0); end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick1();
      if (done0 === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles want 0", seen_done); end
    half0 = 16'd1; dur0 = 16'd1; req0 = 1'b1;
    idle(1);
    checks++; if ({ack0, busy, pwm_ref} !== 7'b1110000) begin errors++; $display("FAIL rst_regrant: got ack0=%0b busy=%0b pwm=%0d want 1 1 16", ack0, busy, pwm_ref); end
    req0 = 1'b0;
    ticks(1); idle(1); ticks(4);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL rst_regrant_done: got %0b want 1", done0); end
    idle(1);
  endtask

  task automatic test_freeze_and_gap0();
    half0 = 16'd1; dur0 = 16'd4; req0 = 1'b1;
    idle(1); req0 = 1'b0;
    idle(10);
    checks++; if ({busy, pwm_ref, done0} !== 7'b1100000) begin errors++; $display("FAIL frz_hold: got busy=%0b pwm=%0d done0=%0b want 1 16 0", busy, pwm_ref, done0); end
    ticks(4); idle(1); ticks(4);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL frz_done: got %0b want 1", done0); end
    idle(1);
    half0 = 16'd1; dur0 = 16'd1; g_req0 = 1'b1;
    idle(1);
    checks++; if ({g_ack0, g_busy, g_pwm_ref} !== 7'b1110000) begin errors++; $display("FAIL g0_grant: got ack0=%0b busy=%0b pwm=%0d want 1 1 16", g_ack0, g_busy, g_pwm_ref); end
    g_req0 = 1'b0;
    ticks(1);
    checks++; if ({g_done0, g_busy, g_pwm_ref} !== 7'b0100000) begin errors++; $display("FAIL g0_gap: got done0=%0b busy=%0b pwm=%0d want 0 1 0", g_done0, g_busy, g_pwm_ref); end
    idle(1);
    checks++; if ({g_done0, g_busy} !== 2'b10) begin errors++; $display("FAIL g0_done: got %b want 10", {g_done0, g_busy}); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_square_wave();
    test_round_robin();
    test_zero_fields();
    test_nonpreempt();
    test_reset_mid_tone();
    test_freeze_and_gap0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
